// File: rtl/nios_noc_pkg.sv
// Shared register map and bit layout for the Nios-facing NoC input port.
package nios_noc_pkg;

   localparam int unsigned CSR_W = 32;

   // Avalon-MM word offsets
   typedef enum logic [1:0] {
      ADDR_DATA     = 2'd0,
      ADDR_STATUS   = 2'd1,
      ADDR_IRQ_MASK = 2'd2,
      ADDR_CONTROL  = 2'd3
   } reg_addr_e;

   // STATUS layout
   localparam int unsigned STAT_NOT_EMPTY_BIT = 0;
   localparam int unsigned STAT_FULL_BIT      = 1;
   localparam int unsigned STAT_BP_SEEN_BIT   = 2;
   localparam int unsigned STAT_COUNT_LSB     = 4;
   localparam int unsigned STAT_COUNT_W       = 5;

   // CONTROL and IRQ_MASK layout
   localparam int unsigned CTRL_FLUSH_BIT     = 0;
   localparam int unsigned CTRL_CLR_BP_BIT    = 1;
   localparam int unsigned IRQ_MASK_EN_BIT    = 0;

   // Assemble the STATUS word; unused bits read 0
   function automatic logic [CSR_W-1:0] pack_status(
      input logic                    not_empty,
      input logic                    full,
      input logic                    bp_seen,
      input logic [STAT_COUNT_W-1:0] count
   );
      logic [CSR_W-1:0] w_word;
      w_word                                 = '0;
      w_word[STAT_NOT_EMPTY_BIT]             = not_empty;
      w_word[STAT_FULL_BIT]                  = full;
      w_word[STAT_BP_SEEN_BIT]               = bp_seen;
      w_word[STAT_COUNT_LSB +: STAT_COUNT_W] = count;
      return w_word;
   endfunction

endpackage

// File: rtl/noc_sync_fifo.sv
// Synchronous FIFO with flush; head word visible combinationally from the read pointer.
module noc_sync_fifo #(
   parameter int unsigned DEPTH  = 4,
   parameter int unsigned DATA_W = 32
) (
   input  logic                   clk,
   input  logic                   reset_n,
   input  logic                   i_push,
   input  logic                   i_pop,
   input  logic                   i_flush,
   input  logic [DATA_W-1:0]      i_data,
   output logic [DATA_W-1:0]      o_head,
   output logic [$clog2(DEPTH):0] o_count,
   output logic                   o_full,
   output logic                   o_empty
);

   localparam int unsigned AW = $clog2(DEPTH);
   localparam int unsigned CW = AW + 1;

   logic [DATA_W-1:0] r_mem [DEPTH];
   logic [AW-1:0]     r_wr_ptr;
   logic [AW-1:0]     r_rd_ptr;
   logic [CW-1:0]     r_count;
   logic              w_push;
   logic              w_pop;

   assign o_full   = (r_count == CW'(DEPTH));
   assign o_empty  = (r_count == '0);
   assign o_count  = r_count;
   assign o_head   = r_mem[r_rd_ptr];
   // Flush overrides both directions; a push into a full FIFO is dropped
   assign w_push   = i_push & ~o_full  & ~i_flush;
   assign w_pop    = i_pop  & ~o_empty & ~i_flush;

   // Pointer and occupancy bookkeeping; pointers wrap naturally at DEPTH
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else if (i_flush) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
         if (w_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
         if (w_push && !w_pop)      r_count <= r_count + CW'(1);
         else if (w_pop && !w_push) r_count <= r_count - CW'(1);
      end
   end

   // Storage array, intentionally not reset
   always_ff @(posedge clk) begin
      if (w_push) r_mem[r_wr_ptr] <= i_data;
   end

endmodule

// File: rtl/noc_input_port.sv
// NoC receive port exposed to a Nios CPU as an Avalon-MM slave.
// Optional level interrupt enabled by defining NOC_INPUT_PORT_IRQ_EN.
module noc_input_port
   import nios_noc_pkg::*;
#(
   parameter int unsigned DEPTH  = 4,
   parameter int unsigned DATA_W = 32
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic [1:0]        address,
   input  logic              chipselect,
   input  logic              read,
   input  logic              write_n,
   input  logic [31:0]       writedata,
   output logic [31:0]       readdata,
   input  logic [DATA_W-1:0] in_data,
   input  logic              in_valid,
   output logic              in_ready,
   output logic              irq
);

   localparam int unsigned CW = $clog2(DEPTH) + 1;

   logic              w_rd;
   logic              w_wr;
   logic              w_ctrl_wr;
   logic              w_flush;
   logic              w_clr_bp;
   logic              w_push;
   logic              w_pop;
   logic [DATA_W-1:0] w_head;
   logic [CW-1:0]     w_count;
   logic              w_full;
   logic              w_empty;
   logic              w_irq_mask;
   logic              r_bp_seen;
   logic              w_unused;

   assign w_rd      = chipselect & read;
   assign w_wr      = chipselect & ~write_n;
   assign w_ctrl_wr = w_wr & (reg_addr_e'(address) == ADDR_CONTROL);
   assign w_flush   = w_ctrl_wr & writedata[CTRL_FLUSH_BIT];
   assign w_clr_bp  = w_ctrl_wr & writedata[CTRL_CLR_BP_BIT];
   assign in_ready  = ~w_full;
   assign w_push    = in_valid & in_ready;
   assign w_pop     = w_rd & (reg_addr_e'(address) == ADDR_DATA) & ~w_empty;
   assign w_unused  = &{1'b0, writedata[31:2]};

   noc_sync_fifo #(
      .DEPTH  (DEPTH),
      .DATA_W (DATA_W)
   ) u_fifo (
      .clk     (clk),
      .reset_n (reset_n),
      .i_push  (w_push),
      .i_pop   (w_pop),
      .i_flush (w_flush),
      .i_data  (in_data),
      .o_head  (w_head),
      .o_count (w_count),
      .o_full  (w_full),
      .o_empty (w_empty)
   );

   // Sticky backpressure flag; a same-cycle set beats the software clear
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n)                 r_bp_seen <= 1'b0;
      else if (in_valid && !in_ready) r_bp_seen <= 1'b1;
      else if (w_clr_bp)            r_bp_seen <= 1'b0;
   end

`ifdef NOC_INPUT_PORT_IRQ_EN
   logic r_irq_mask;
   logic r_irq;

   // Interrupt mask register and registered level interrupt
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_irq_mask <= 1'b0;
         r_irq      <= 1'b0;
      end else begin
         if (w_wr && (reg_addr_e'(address) == ADDR_IRQ_MASK))
            r_irq_mask <= writedata[IRQ_MASK_EN_BIT];
         r_irq <= r_irq_mask & ~w_empty;
      end
   end

   assign w_irq_mask = r_irq_mask;
   assign irq        = r_irq;
`else
   assign w_irq_mask = 1'b0;
   assign irq        = 1'b0;
`endif

   // Zero-latency read mux; only a DATA read has a side effect (the pop)
   always_comb begin
      readdata = '0;
      if (w_rd) begin
         case (reg_addr_e'(address))
            ADDR_DATA:     if (!w_empty) readdata = 32'(w_head);
            ADDR_STATUS:   readdata = pack_status(~w_empty, w_full, r_bp_seen,
                                                  STAT_COUNT_W'(w_count));
            ADDR_IRQ_MASK: readdata = {31'd0, w_irq_mask};
            default:       readdata = '0;
         endcase
      end
   end

endmodule

// File: tb/tb_noc_input_port.sv
// Randomized and directed bench for noc_input_port against a queue-based reference.
module tb_noc_input_port;

   localparam int unsigned DEPTH = 4;

   logic        clk = 1'b0;
   logic        reset_n;
   logic [1:0]  address;
   logic        chipselect;
   logic        read;
   logic        write_n;
   logic [31:0] writedata;
   logic [31:0] readdata;
   logic [31:0] in_data;
   logic        in_valid;
   logic        in_ready;
   logic        irq;

   int unsigned n_checks = 0;
   int unsigned n_errors = 0;

   // Reference state
   logic [31:0] q[$];
   bit          m_bp;
   bit          m_mask;
   bit          m_irq;
   logic [31:0] last_rd;

   noc_input_port #(.DEPTH(DEPTH), .DATA_W(32)) dut (
      .clk        (clk),
      .reset_n    (reset_n),
      .address    (address),
      .chipselect (chipselect),
      .read       (read),
      .write_n    (write_n),
      .writedata  (writedata),
      .readdata   (readdata),
      .in_data    (in_data),
      .in_valid   (in_valid),
      .in_ready   (in_ready),
      .irq        (irq)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Expected read value at an address, from the reference state
   function automatic logic [31:0] exp_read(input logic [1:0] a);
      int sz;
      sz = q.size();
      case (a)
         2'd0: return (sz > 0) ? q[0] : 32'd0;
         2'd1: return 32'((sz > 0) ? 1 : 0) + 32'((sz == DEPTH) ? 2 : 0)
                      + 32'(m_bp ? 4 : 0) + 32'(sz * 16);
         2'd2: return {31'd0, m_mask};
         default: return 32'd0;
      endcase
   endfunction

   // One bus/stream cycle: op 0 idle, 1 read, 2 write. Entered and left at negedge.
   task automatic step(input bit v, input logic [31:0] d, input int op,
                       input logic [1:0] a, input logic [31:0] wd);
      bit ready, push, pop, ctrl, nonempty_before;
      in_valid   = v;
      in_data    = d;
      chipselect = (op != 0);
      read       = (op == 1);
      write_n    = !(op == 2);
      address    = a;
      writedata  = wd;
      #1;
      ready = (q.size() < DEPTH);
      chk("in_ready", 32'(in_ready), 32'(ready));
      chk("irq", 32'(irq), 32'(m_irq));
      if (op == 1) begin
         last_rd = readdata;
         chk($sformatf("readdata@%0d", a), readdata, exp_read(a));
      end
      @(posedge clk);
      nonempty_before = (q.size() > 0);
      push = v && ready;
      pop  = (op == 1) && (a == 2'd0) && (q.size() > 0);
      ctrl = (op == 2) && (a == 2'd3);
`ifdef NOC_INPUT_PORT_IRQ_EN
      m_irq = m_mask && nonempty_before;
      if (op == 2 && a == 2'd2) m_mask = wd[0];
`endif
      if (v && !ready)       m_bp = 1'b1;
      else if (ctrl && wd[1]) m_bp = 1'b0;
      if (ctrl && wd[0]) q.delete();
      else begin
         if (pop)  void'(q.pop_front());
         if (push) q.push_back(d);
      end
      @(negedge clk);
   endtask

   initial begin
      in_valid = 0; in_data = '0; chipselect = 1; read = 1; write_n = 1;
      address = 2'd0; writedata = '0; reset_n = 1'b0;
      m_bp = 0; m_mask = 0; m_irq = 0; last_rd = '0;
      #12;
      chk("rst_in_ready", 32'(in_ready), 32'd1);
      chk("rst_readdata", readdata, 32'd0);
      chk("rst_irq", 32'(irq), 32'd0);
      @(negedge clk);
      reset_n = 1'b1;

      // First-word latency and pop
      step(1, 32'hA5A5_0001, 0, 0, 0);
      step(0, 0, 1, 0, 0);
      chk("first_word", last_rd, 32'hA5A5_0001);
      step(0, 0, 1, 1, 0);
      chk("status_after_pop", last_rd, 32'h0);

      // Empty DATA read has no effect
      step(0, 0, 1, 0, 0);
      chk("empty_read", last_rd, 32'h0);
      step(0, 0, 1, 1, 0);
      chk("empty_status", last_rd, 32'h0);

      // Fill past DEPTH while holding valid
      for (int i = 1; i <= 4; i++) step(1, 32'(i), 0, 0, 0);
      step(1, 32'd5, 0, 0, 0);
      step(1, 32'd5, 1, 1, 0);
      chk("status_full", last_rd, 32'h47);
      step(1, 32'd5, 1, 0, 0);
      chk("pop1", last_rd, 32'd1);
      step(1, 32'd5, 1, 0, 0);
      chk("pop2", last_rd, 32'd2);
      step(0, 0, 1, 0, 0);
      chk("pop3", last_rd, 32'd3);
      step(0, 0, 1, 0, 0);
      chk("pop4", last_rd, 32'd4);
      step(0, 0, 1, 0, 0);
      chk("pop5", last_rd, 32'd5);

      // Clear bp_seen
      step(0, 0, 2, 3, 32'h2);
      step(0, 0, 1, 1, 0);
      chk("bp_cleared", last_rd, 32'h0);

      // Simultaneous push and pop at count 2
      step(1, 32'h11, 0, 0, 0);
      step(1, 32'h22, 0, 0, 0);
      step(1, 32'h33, 1, 0, 0);
      chk("pushpop_oldest", last_rd, 32'h11);
      step(0, 0, 1, 1, 0);
      chk("pushpop_count", last_rd, 32'h21);

      // Flush wins over same-cycle push; ignored writes to DATA/STATUS
      step(1, 32'h44, 2, 3, 32'h1);
      step(0, 0, 1, 1, 0);
      chk("flush_status", last_rd, 32'h0);
      step(1, 32'h55, 2, 0, 32'hFFFF_FFFF);
      step(0, 0, 2, 1, 32'hFFFF_FFFF);
      step(0, 0, 1, 1, 0);
      chk("ignored_writes", last_rd, 32'h11);

      // IRQ mask and interrupt behaviour
      step(0, 0, 2, 2, 32'h1);
      step(0, 0, 1, 2, 0);
      step(0, 0, 1, 0, 0);
      step(1, 32'h66, 0, 0, 0);
      step(0, 0, 0, 0, 0);
      step(0, 0, 1, 0, 0);
      step(0, 0, 0, 0, 0);
      step(0, 0, 0, 0, 0);

      // Randomized traffic
      for (int n = 0; n < 400; n++) begin
         int r;
         bit v;
         r = int'($urandom_range(0, 9));
         v = ($urandom_range(0, 3) != 0);
         if (r < 2)       step(v, $urandom, 1, 2'd0, 0);
         else if (r < 4)  step(v, $urandom, 1, 2'($urandom_range(1, 3)), 0);
         else if (r == 4) step(v, $urandom, 2, 2'd3, 32'($urandom_range(0, 3)));
         else if (r == 5) step(v, $urandom, 2, 2'($urandom_range(0, 2)), $urandom);
         else             step(v, $urandom, 0, 2'd0, 0);
      end

      // Reset mid-burst
      step(0, 0, 2, 2, 32'h1);
      step(1, 32'h77, 0, 0, 0);
      step(1, 32'h88, 0, 0, 0);
      in_valid = 1; chipselect = 1; read = 1; write_n = 1; address = 2'd1;
      #2 reset_n = 1'b0;
      #1;
      chk("midrst_irq", 32'(irq), 32'd0);
      chk("midrst_in_ready", 32'(in_ready), 32'd1);
      chk("midrst_status", readdata, 32'h0);
      q.delete(); m_bp = 0; m_mask = 0; m_irq = 0;
      in_valid = 0;
      @(negedge clk);
      reset_n = 1'b1;
      step(0, 0, 1, 0, 0);
      chk("post_rst_data", last_rd, 32'h0);
      step(0, 0, 1, 2, 0);
      chk("post_rst_mask", last_rd, 32'h0);

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
